// File: rtl/lut_udp_reg.sv
// lut_udp_reg: run-time reprogrammable N_IN-input truth table with a
// registered lookup stage. A new table is shifted in serially over a
// ready/valid port into a shadow register and committed atomically.
module lut_udp_reg #(
  parameter int unsigned               N_IN = 3,
  parameter logic [(1 << N_IN)-1:0]    INIT = 8'hD5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N_IN-1:0] a,
  input  logic            d,
  output logic            out_valid,
  output logic            e,
  output logic            f,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic            cfg_bit,
  input  logic            cfg_last,
  output logic            cfg_err,
  input  logic            cfg_err_clr
);

  localparam int unsigned W  = 1 << N_IN;
  localparam int unsigned CW = N_IN + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    tbl;
  logic [W-1:0]    shd;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            err_set;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, handshake and framing-error decode.
  // N_IN >= 1 keeps W >= 2, so a single-bit frame can never be complete
  // and IDLE always moves on to LOAD.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b1;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_valid) state_nxt = LOAD;
      end
      LOAD: begin
        if (cfg_valid) begin
          if (cfg_last && cnt == LAST_IDX) begin
            state_nxt = COMMIT;
          end else if (cfg_last || cnt == LAST_IDX) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      COMMIT: begin
        cfg_ready = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = cfg_valid & cfg_ready;
  end

  // Shadow collection, bit counter, atomic table commit and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd     <= '0;
      cnt     <= '0;
      tbl     <= INIT;
      cfg_err <= 1'b0;
    end else begin
      if (err_set)          cfg_err <= 1'b1;
      else if (cfg_err_clr) cfg_err <= 1'b0;

      if (state == COMMIT) begin
        tbl <= shd;
        cnt <= '0;
      end else if (accept) begin
        if (err_set) begin
          shd <= '0;
          cnt <= '0;
        end else begin
          shd <= {shd[W-2:0], cfg_bit};
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Registered lookup; e/f hold when no sample is presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      e         <= 1'b0;
      f         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        e <= tbl[a];
        f <= tbl[a] & d;
      end
    end
  end

endmodule

// File: tb/tb_lut_udp_reg.sv
// tb_lut_udp_reg: directed checks of lookup, serial load/commit, framing
// errors, asynchronous reset and a 4-input build with gapped loading.
module tb_lut_udp_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv3, d3, ov3, e3, f3, cv3, cr3, cb3, cl3, ce3, cc3;
  logic [2:0] a3;
  logic       iv4, d4, ov4, e4, f4, cv4, cr4, cb4, cl4, ce4, cc4;
  logic [3:0] a4;

  int n_vec = 0;
  int n_err = 0;

  lut_udp_reg dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .a(a3), .d(d3),
    .out_valid(ov3), .e(e3), .f(f3), .cfg_valid(cv3), .cfg_ready(cr3),
    .cfg_bit(cb3), .cfg_last(cl3), .cfg_err(ce3), .cfg_err_clr(cc3)
  );

  lut_udp_reg #(.N_IN(4), .INIT(16'h0001)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .d(d4),
    .out_valid(ov4), .e(e4), .f(f4), .cfg_valid(cv4), .cfg_ready(cr4),
    .cfg_bit(cb4), .cfg_last(cl4), .cfg_err(ce4), .cfg_err_clr(cc4)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input bit sel, input logic v, input logic b,
                           input logic l, input logic c);
    if (sel) begin cv4 = v; cb4 = b; cl4 = l; cc4 = c; end
    else     begin cv3 = v; cb3 = b; cl3 = l; cc3 = c; end
  endtask

  // Serial load, MSB (minterm n-1) first; optional idle gap every gap_every bits
  task automatic send(input bit sel, input logic [15:0] val, input int n,
                      input bit with_last, input bit clr_last, input int gap_every);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap_every != 0 && i != n - 1 && ((n - 1 - i) % gap_every) == 0) begin
        drive_cfg(sel, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
      end
      check("cfg_ready_load", sel ? cr4 : cr3, 1'b1);
      drive_cfg(sel, 1'b1, val[i], with_last && i == 0, clr_last && i == 0);
      tick();
    end
    drive_cfg(sel, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sweep(input bit sel, input logic [15:0] exp_tbl, input logic dv,
                       input string tag);
    int n;
    n = sel ? 16 : 8;
    for (int i = 0; i < n; i++) begin
      if (sel) begin iv4 = 1'b1; a4 = i[3:0]; d4 = dv; end
      else     begin iv3 = 1'b1; a3 = i[2:0]; d3 = dv; end
      tick();
      check({tag, "_e"},  sel ? e4 : e3,   exp_tbl[i]);
      check({tag, "_f"},  sel ? f4 : f3,   exp_tbl[i] & dv);
      check({tag, "_ov"}, sel ? ov4 : ov3, 1'b1);
    end
    if (sel) iv4 = 1'b0;
    else     iv3 = 1'b0;
    tick();
    check({tag, "_ov_idle"}, sel ? ov4 : ov3, 1'b0);
    check({tag, "_e_hold"},  sel ? e4 : e3,   exp_tbl[n-1]);
  endtask

  // Lookup of a=0 presented in the COMMIT cycle must see the old table
  task automatic commit_probe(input logic old_bit0, input string tag);
    check({tag, "_commit_rdy"}, cr3, 1'b0);
    iv3 = 1'b1; a3 = 3'd0; d3 = 1'b1;
    tick();
    check({tag, "_commit_old"}, e3, old_bit0);
    check({tag, "_rdy_back"}, cr3, 1'b1);
    iv3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    iv3 = 0; a3 = '0; d3 = 0; cv3 = 0; cb3 = 0; cl3 = 0; cc3 = 0;
    iv4 = 0; a4 = '0; d4 = 0; cv4 = 0; cb4 = 0; cl4 = 0; cc4 = 0;
    #12;
    check("rst_e",   e3,  1'b0);
    check("rst_f",   f3,  1'b0);
    check("rst_ov",  ov3, 1'b0);
    check("rst_err", ce3, 1'b0);
    check("rst_rdy", cr3, 1'b1);
    check("rst_rdy4", cr4, 1'b1);
    rst = 1'b0;
    tick();

    sweep(1'b0, 16'h00D5, 1'b1, "init_d1");
    sweep(1'b0, 16'h00D5, 1'b0, "init_d0");

    // Short frame: 5 bits, last on the 5th
    send(1'b0, 16'h001F, 5, 1'b1, 1'b0, 0);
    check("short_err", ce3, 1'b1);
    check("short_rdy", cr3, 1'b1);
    sweep(1'b0, 16'h00D5, 1'b1, "short_tbl");
    cc3 = 1'b1;
    tick();
    cc3 = 1'b0;
    check("clr_err", ce3, 1'b0);

    // Short frame with clear asserted on the offending bit: set wins
    send(1'b0, 16'h0003, 2, 1'b1, 1'b1, 0);
    check("set_wins", ce3, 1'b1);
    cc3 = 1'b1;
    tick();
    cc3 = 1'b0;
    check("clr_err2", ce3, 1'b0);

    // Long frame: 8 bits, no last
    send(1'b0, 16'h0000, 8, 1'b0, 1'b0, 0);
    check("long_err", ce3, 1'b1);
    check("long_idle", cr3, 1'b1);
    sweep(1'b0, 16'h00D5, 1'b1, "long_tbl");

    // Load 8'h80 from D5
    send(1'b0, 16'h0080, 8, 1'b1, 1'b0, 0);
    commit_probe(1'b1, "ld80");
    sweep(1'b0, 16'h0080, 1'b1, "tbl80");

    // Load 8'hFF from 80; error flag is informational and stays set
    send(1'b0, 16'h00FF, 8, 1'b1, 1'b0, 0);
    commit_probe(1'b0, "ldff");
    check("err_sticky", ce3, 1'b1);
    sweep(1'b0, 16'h00FF, 1'b1, "tblff");

    // Reset mid-load while lookups run
    iv3 = 1'b1; a3 = 3'd7; d3 = 1'b1;
    send(1'b0, 16'h0000, 4, 1'b0, 1'b0, 0);
    check("load_lookup_e",  e3,  1'b1);
    check("load_lookup_ov", ov3, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_e",   e3,  1'b0);
    check("arst_f",   f3,  1'b0);
    check("arst_ov",  ov3, 1'b0);
    check("arst_err", ce3, 1'b0);
    check("arst_rdy", cr3, 1'b1);
    #1 rst = 1'b0;
    iv3 = 1'b0;
    tick();
    sweep(1'b0, 16'h00D5, 1'b1, "arst_tbl");

    // 4-input instance: init table, then gapped 16-bit load
    sweep(1'b1, 16'h0001, 1'b1, "n4_init");
    send(1'b1, 16'hA5C3, 16, 1'b1, 1'b0, 5);
    check("n4_commit_rdy", cr4, 1'b0);
    tick();
    check("n4_rdy_back", cr4, 1'b1);
    check("n4_err", ce4, 1'b0);
    sweep(1'b1, 16'hA5C3, 1'b1, "n4_tbl");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
